// File: rtl/note_scroller.sv
// note_scroller: falling-note engine for Squat Hero.
//
// Holds up to NUM_SLOTS notes. Each note is a NOTE_W x NOTE_H rectangle in
// one of four lanes. Every note moves down by SPEED once per frame, on the
// vsync falling edge. Spawn requests come from the song sequencer and hit
// requests come from the squat detector. Hits and misses are scored. The
// block also gives videoGen per-pixel note and hit-line flags for the
// current x,y.
//
// Build option: define MISS_ON_EMPTY_HIT_EN to score a hit_req that matches
// no note as a miss. If it is undefined, such a hit_req is ignored.
//
// Ports:
//   reset          async, active-high reset
//   vgaclk         pixel clock
//   x, y           current pixel column and row
//   vsync          active-low vertical sync
//   spawn_valid    spawn request
//   spawn_lane     lane of the requested note
//   spawn_ready    high while at least one slot is free
//   hit_req        one-cycle squat-detected pulse
//   hit_lane       lane the player targeted
//   note_pixel     x,y lies inside a live note
//   hitline_pixel  y lies in [HIT_Y, HIT_Y+2)
//   hit_pulse      one-cycle pulse when a hit is scored
//   miss_pulse     one-cycle pulse when one or more misses are scored
//   hit_cnt        saturating hit count
//   miss_cnt       saturating miss count
//
// Spawn handshake: a note is accepted on any rising vgaclk edge where
// spawn_valid and spawn_ready are both high. spawn_ready depends only on
// registered slot state. A request made while spawn_ready is low is dropped,
// not queued.
module note_scroller #(
  parameter int         NUM_SLOTS  = 4,
  parameter logic [9:0] NOTE_W     = 10'd64,
  parameter logic [9:0] NOTE_H     = 10'd16,
  parameter logic [9:0] LANE_X0    = 10'd64,
  parameter logic [9:0] LANE_PITCH = 10'd128,
  parameter logic [9:0] SPEED      = 10'd2,
  parameter logic [9:0] Y_START    = 10'd0,
  parameter logic [9:0] Y_END      = 10'd480,
  parameter logic [9:0] HIT_Y      = 10'd400,
  parameter logic [9:0] HIT_WIN    = 10'd16
) (
  input  logic       reset,
  input  logic       vgaclk,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       vsync,
  input  logic       spawn_valid,
  input  logic [1:0] spawn_lane,
  output logic       spawn_ready,
  input  logic       hit_req,
  input  logic [1:0] hit_lane,
  output logic       note_pixel,
  output logic       hitline_pixel,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] hit_cnt,
  output logic [7:0] miss_cnt
);

  // The hit window is computed in 11 bits. The lower bound stops at 0 so
  // the subtraction cannot wrap.
  localparam logic [10:0] HIT_LO = (HIT_Y >= HIT_WIN) ?
                                   ({1'b0, HIT_Y} - {1'b0, HIT_WIN}) : 11'd0;
  localparam logic [10:0] HIT_HI = {1'b0, HIT_Y} + {1'b0, HIT_WIN};

  logic [NUM_SLOTS-1:0] valid;
  logic [1:0]           lane [NUM_SLOTS];
  logic [9:0]           ypos [NUM_SLOTS];
  logic                 vsync_q;
  logic                 frame_tick;

  logic [NUM_SLOTS-1:0] spawn_sel;   // one-hot: slot that takes the spawn
  logic [NUM_SLOTS-1:0] hit_sel;     // one-hot: slot cleared by the hit
  logic [NUM_SLOTS-1:0] expired;
  logic [10:0]          adv_sum [NUM_SLOTS];
  logic                 hit_found;
  logic                 empty_miss;
  logic [3:0]           miss_add;
  logic [8:0]           miss_sum;
  logic [8:0]           hit_sum;

  assign frame_tick  = vsync_q & ~vsync;
  assign spawn_ready = ~&valid;

  // All decisions below use only the state from before the edge. A slot
  // freed by a hit or an expiry can take a spawn only on a later cycle.
  always_comb begin
    logic spawn_taken;
    logic hit_taken;
    spawn_sel   = '0;
    hit_sel     = '0;
    expired     = '0;
    spawn_taken = 1'b0;
    hit_taken   = 1'b0;
    miss_add    = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      adv_sum[i] = {1'b0, ypos[i]} + {1'b0, SPEED};
      if (!valid[i] && !spawn_taken) begin
        spawn_sel[i] = spawn_valid;
        spawn_taken  = 1'b1;
      end
      if (hit_req && valid[i] && !hit_taken && (lane[i] == hit_lane) &&
          ({1'b0, ypos[i]} >= HIT_LO) && ({1'b0, ypos[i]} <= HIT_HI)) begin
        hit_sel[i] = 1'b1;
        hit_taken  = 1'b1;
      end
    end
    // A slot cleared by a hit on this same tick does not count as expired.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      expired[i] = valid[i] & frame_tick & ~hit_sel[i] &
                   (adv_sum[i] >= {1'b0, Y_END});
      miss_add   = miss_add + {3'd0, expired[i]};
    end
    hit_found = hit_taken;
`ifdef MISS_ON_EMPTY_HIT_EN
    empty_miss = hit_req & ~hit_taken;
`else
    empty_miss = 1'b0;
`endif
    miss_add = miss_add + {3'd0, empty_miss};
    miss_sum = {1'b0, miss_cnt} + {5'd0, miss_add};
    hit_sum  = {1'b0, hit_cnt} + 9'd1;
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      valid      <= '0;
      vsync_q    <= 1'b1;
      hit_cnt    <= 8'd0;
      miss_cnt   <= 8'd0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        lane[i] <= 2'd0;
        ypos[i] <= 10'd0;
      end
    end else begin
      vsync_q    <= vsync;
      hit_pulse  <= hit_found;
      miss_pulse <= (miss_add != 4'd0);
      if (hit_found)
        hit_cnt <= (hit_sum > 9'd255) ? 8'd255 : hit_sum[7:0];
      miss_cnt <= (miss_sum > 9'd255) ? 8'd255 : miss_sum[7:0];
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (hit_sel[i] || expired[i])
          valid[i] <= 1'b0;
        else if (valid[i] && frame_tick)
          ypos[i] <= adv_sum[i][9:0];
        // A spawn can only select a slot that was free, so it never
        // conflicts with the hit or advance branches above.
        if (spawn_sel[i]) begin
          valid[i] <= 1'b1;
          lane[i]  <= spawn_lane;
          ypos[i]  <= Y_START;
        end
      end
    end
  end

  // Pixel flags have zero latency. They are not gated by blanking.
  always_comb begin
    logic [10:0] lx;
    logic [10:0] x11;
    logic [10:0] y11;
    x11        = {1'b0, x};
    y11        = {1'b0, y};
    note_pixel = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      lx = {1'b0, LANE_X0} + ({9'd0, lane[i]} * {1'b0, LANE_PITCH});
      if (valid[i] && (x11 >= lx) && (x11 < lx + {1'b0, NOTE_W}) &&
          (y11 >= {1'b0, ypos[i]}) &&
          (y11 < {1'b0, ypos[i]} + {1'b0, NOTE_H}))
        note_pixel = 1'b1;
    end
    hitline_pixel = (y11 >= {1'b0, HIT_Y}) && (y11 < {1'b0, HIT_Y} + 11'd2);
  end

endmodule

// File: tb/tb_note_scroller.sv
module tb_note_scroller;

  logic       reset;
  logic       vgaclk;
  logic [9:0] x;
  logic [9:0] y;
  logic       vsync;
  logic       spawn_valid;
  logic [1:0] spawn_lane;
  logic       spawn_ready;
  logic       hit_req;
  logic [1:0] hit_lane;
  logic       note_pixel;
  logic       hitline_pixel;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] hit_cnt;
  logic [7:0] miss_cnt;

  int errors = 0;
  int checks = 0;

`ifdef MISS_ON_EMPTY_HIT_EN
  localparam logic [7:0] EMPTY_MISS = 8'd1;
`else
  localparam logic [7:0] EMPTY_MISS = 8'd0;
`endif

  note_scroller dut (
    .reset(reset), .vgaclk(vgaclk), .x(x), .y(y), .vsync(vsync),
    .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_ready(spawn_ready),
    .hit_req(hit_req), .hit_lane(hit_lane), .note_pixel(note_pixel),
    .hitline_pixel(hitline_pixel), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // clock / reset
  initial vgaclk = 1'b0;
  always #20 vgaclk = ~vgaclk;

  // driver tasks
  task automatic step();
    @(posedge vgaclk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; spawn_valid = 1'b0; hit_req = 1'b0; vsync = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      vsync = 1'b0; step();
      vsync = 1'b1; step();
    end
  endtask

  task automatic spawn(input logic [1:0] l);
    spawn_valid = 1'b1; spawn_lane = l; step(); spawn_valid = 1'b0;
  endtask

  task automatic hit(input logic [1:0] l);
    hit_req = 1'b1; hit_lane = l; step(); hit_req = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    apply_reset();
    checks++; if (spawn_ready !== 1'b1) begin errors++; $display("FAIL reset_spawn_ready got=%b exp=1", spawn_ready); end
    checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL reset_hit_cnt got=%0d exp=0", hit_cnt); end
    checks++; if (miss_cnt !== 8'd0) begin errors++; $display("FAIL reset_miss_cnt got=%0d exp=0", miss_cnt); end
    checks++; if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", hit_pulse, miss_pulse); end
    x = 10'd64; y = 10'd0; #1;
    checks++; if (note_pixel !== 1'b0) begin errors++; $display("FAIL reset_note_pixel got=%b exp=0", note_pixel); end
    y = 10'd400; #1;
    checks++; if (hitline_pixel !== 1'b1) begin errors++; $display("FAIL hitline_400 got=%b exp=1", hitline_pixel); end
    y = 10'd401; #1;
    checks++; if (hitline_pixel !== 1'b1) begin errors++; $display("FAIL hitline_401 got=%b exp=1", hitline_pixel); end
    y = 10'd402; #1;
    checks++; if (hitline_pixel !== 1'b0) begin errors++; $display("FAIL hitline_402 got=%b exp=0", hitline_pixel); end
    y = 10'd399; #1;
    checks++; if (hitline_pixel !== 1'b0) begin errors++; $display("FAIL hitline_399 got=%b exp=0", hitline_pixel); end
  endtask

  task automatic test_spawn_pixel();
    apply_reset();
    spawn(2'd1);
    checks++; if (spawn_ready !== 1'b1) begin errors++; $display("FAIL spawn1_ready got=%b exp=1", spawn_ready); end
    x = 10'd192; y = 10'd0; #1;
    checks++; if (note_pixel !== 1'b1) begin errors++; $display("FAIL pix_192_0 got=%b exp=1", note_pixel); end
    x = 10'd191; #1;
    checks++; if (note_pixel !== 1'b0) begin errors++; $display("FAIL pix_191_0 got=%b exp=0", note_pixel); end
    x = 10'd192; y = 10'd16; #1;
    checks++; if (note_pixel !== 1'b0) begin errors++; $display("FAIL pix_192_16 got=%b exp=0", note_pixel); end
    x = 10'd255; y = 10'd15; #1;
    checks++; if (note_pixel !== 1'b1) begin errors++; $display("FAIL pix_255_15 got=%b exp=1", note_pixel); end
    x = 10'd256; #1;
    checks++; if (note_pixel !== 1'b0) begin errors++; $display("FAIL pix_256_15 got=%b exp=0", note_pixel); end
  endtask

  task automatic test_hit();
    apply_reset();
    spawn(2'd0);
    ticks(200);
    x = 10'd64; y = 10'd400; #1;
    checks++; if (note_pixel !== 1'b1) begin errors++; $display("FAIL pre_hit_pix_400 got=%b exp=1", note_pixel); end
    y = 10'd399; #1;
    checks++; if (note_pixel !== 1'b0) begin errors++; $display("FAIL pre_hit_pix_399 got=%b exp=0", note_pixel); end
    y = 10'd400;
    hit(2'd0);
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL hit_pulse got=%b exp=1", hit_pulse); end
    checks++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL hit_cnt got=%0d exp=1", hit_cnt); end
    checks++; if (note_pixel !== 1'b0) begin errors++; $display("FAIL hit_slot_freed got=%b exp=0", note_pixel); end
    step();
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL hit_pulse_drop got=%b exp=0", hit_pulse); end
  endtask

  task automatic test_hit_window();
    apply_reset();
    spawn(2'd0);
    ticks(191);                         // ypos 382, just outside the window
    hit(2'd0);
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL win382_hit_pulse got=%b exp=0", hit_pulse); end
    checks++; if (miss_cnt !== EMPTY_MISS) begin errors++; $display("FAIL win382_miss_cnt got=%0d exp=%0d", miss_cnt, EMPTY_MISS); end
    ticks(1);                           // ypos 384, lower edge of the window
    hit(2'd0);
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL win384_hit_pulse got=%b exp=1", hit_pulse); end
  endtask

  task automatic test_expire();
    apply_reset();
    spawn(2'd2);
    ticks(239);                         // ypos 478
    x = 10'd320; y = 10'd478; #1;
    checks++; if (note_pixel !== 1'b1) begin errors++; $display("FAIL pix_478 got=%b exp=1", note_pixel); end
    checks++; if (miss_cnt !== 8'd0) begin errors++; $display("FAIL pre_expire_miss got=%0d exp=0", miss_cnt); end
    vsync = 1'b0; step(); vsync = 1'b1;
    checks++; if (miss_pulse !== 1'b1) begin errors++; $display("FAIL expire_miss_pulse got=%b exp=1", miss_pulse); end
    checks++; if (miss_cnt !== 8'd1) begin errors++; $display("FAIL expire_miss_cnt got=%0d exp=1", miss_cnt); end
    checks++; if (note_pixel !== 1'b0) begin errors++; $display("FAIL expire_pixel got=%b exp=0", note_pixel); end
    step();
    checks++; if (miss_pulse !== 1'b0) begin errors++; $display("FAIL miss_pulse_drop got=%b exp=0", miss_pulse); end
  endtask

  task automatic test_full();
    apply_reset();
    spawn_valid = 1'b1;
    for (int l = 0; l < 4; l++) begin spawn_lane = 2'(l); step(); end
    spawn_valid = 1'b0;
    checks++; if (spawn_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", spawn_ready); end
    ticks(200);                         // all four at ypos 400
    spawn(2'd1);                        // dropped: no slot free
    x = 10'd192; y = 10'd0; #1;
    checks++; if (note_pixel !== 1'b0) begin errors++; $display("FAIL full_spawn_dropped got=%b exp=0", note_pixel); end
    spawn_valid = 1'b1; spawn_lane = 2'd1; hit_req = 1'b1; hit_lane = 2'd0;
    step();
    hit_req = 1'b0;
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL full_hit_pulse got=%b exp=1", hit_pulse); end
    checks++; if (spawn_ready !== 1'b1) begin errors++; $display("FAIL full_freed_ready got=%b exp=1", spawn_ready); end
    checks++; if (note_pixel !== 1'b0) begin errors++; $display("FAIL same_cycle_spawn got=%b exp=0", note_pixel); end
    step();
    spawn_valid = 1'b0;
    checks++; if (spawn_ready !== 1'b0) begin errors++; $display("FAIL next_cycle_ready got=%b exp=0", spawn_ready); end
    checks++; if (note_pixel !== 1'b1) begin errors++; $display("FAIL next_cycle_spawn got=%b exp=1", note_pixel); end
  endtask

  task automatic test_double_miss();
    apply_reset();
    spawn(2'd0);
    spawn(2'd1);
    ticks(239);
    vsync = 1'b0; step(); vsync = 1'b1;
    checks++; if (miss_cnt !== 8'd2) begin errors++; $display("FAIL double_miss_cnt got=%0d exp=2", miss_cnt); end
    checks++; if (miss_pulse !== 1'b1) begin errors++; $display("FAIL double_miss_pulse got=%b exp=1", miss_pulse); end
    step();
  endtask

  task automatic test_hit_on_tick();
    apply_reset();
    spawn(2'd3);
    spawn(2'd2);
    ticks(195);                         // both at ypos 390
    vsync = 1'b0; hit_req = 1'b1; hit_lane = 2'd3;
    step();
    hit_req = 1'b0; vsync = 1'b1;
    checks++; if (hit_pulse !== 1'b1 || hit_cnt !== 8'd1) begin errors++; $display("FAIL tick_hit got=%b/%0d exp=1/1", hit_pulse, hit_cnt); end
    checks++; if (miss_pulse !== 1'b0 || miss_cnt !== 8'd0) begin errors++; $display("FAIL tick_hit_miss got=%b/%0d exp=0/0", miss_pulse, miss_cnt); end
    x = 10'd448; y = 10'd392; #1;
    checks++; if (note_pixel !== 1'b0) begin errors++; $display("FAIL tick_hit_cleared got=%b exp=0", note_pixel); end
    x = 10'd320; #1;
    checks++; if (note_pixel !== 1'b1) begin errors++; $display("FAIL other_advanced got=%b exp=1", note_pixel); end
    y = 10'd391; #1;
    checks++; if (note_pixel !== 1'b0) begin errors++; $display("FAIL other_top_391 got=%b exp=0", note_pixel); end
    step();
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int r = 0; r < 63; r++) begin
      for (int l = 0; l < 4; l++) spawn(2'(l));
      ticks(200);
      for (int l = 0; l < 4; l++) hit(2'(l));
    end
    checks++; if (hit_cnt !== 8'd252) begin errors++; $display("FAIL hit_cnt_252 got=%0d exp=252", hit_cnt); end
    for (int l = 0; l < 4; l++) spawn(2'(l));
    ticks(200);
    for (int l = 0; l < 3; l++) hit(2'(l));
    checks++; if (hit_cnt !== 8'd255) begin errors++; $display("FAIL hit_cnt_255 got=%0d exp=255", hit_cnt); end
    hit(2'd3);
    checks++; if (hit_cnt !== 8'd255) begin errors++; $display("FAIL hit_cnt_sat got=%0d exp=255", hit_cnt); end
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL sat_hit_pulse got=%b exp=1", hit_pulse); end
  endtask

  task automatic test_reset_mid();
    // continues from the saturated state left by test_saturation
    for (int l = 0; l < 4; l++) spawn(2'(l));
    ticks(2);
    x = 10'd64; y = 10'd4; #1;
    checks++; if (note_pixel !== 1'b1 || spawn_ready !== 1'b0) begin errors++; $display("FAIL pre_reset got=%b/%b exp=1/0", note_pixel, spawn_ready); end
    #5 reset = 1'b1;
    #1;
    checks++; if (note_pixel !== 1'b0 || spawn_ready !== 1'b1) begin errors++; $display("FAIL async_reset_slots got=%b/%b exp=0/1", note_pixel, spawn_ready); end
    checks++; if (hit_cnt !== 8'd0 || miss_cnt !== 8'd0) begin errors++; $display("FAIL async_reset_cnts got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    step();
    reset = 1'b0;
    step();
    ticks(240);
    checks++; if (miss_cnt !== 8'd0) begin errors++; $display("FAIL reset_no_miss got=%0d exp=0", miss_cnt); end
  endtask

  task automatic test_empty_hit();
    apply_reset();
    hit(2'd2);
    checks++; if (miss_pulse !== EMPTY_MISS[0]) begin errors++; $display("FAIL empty_hit_pulse got=%b exp=%b", miss_pulse, EMPTY_MISS[0]); end
    checks++; if (miss_cnt !== EMPTY_MISS) begin errors++; $display("FAIL empty_hit_cnt got=%0d exp=%0d", miss_cnt, EMPTY_MISS); end
    checks++; if (hit_pulse !== 1'b0 || hit_cnt !== 8'd0) begin errors++; $display("FAIL empty_hit_scored got=%b/%0d exp=0/0", hit_pulse, hit_cnt); end
  endtask

  initial begin
    reset = 1'b1; x = 10'd0; y = 10'd0; vsync = 1'b1;
    spawn_valid = 1'b0; spawn_lane = 2'd0; hit_req = 1'b0; hit_lane = 2'd0;
    test_reset();
    test_spawn_pixel();
    test_hit();
    test_hit_window();
    test_expire();
    test_full();
    test_double_miss();
    test_hit_on_tick();
    test_saturation();
    test_reset_mid();
    test_empty_hit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
